// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: isolates, resets, and clock-gates each external cluster on request,
// then reverses the order on wake-up. Every cluster runs its own independent FSM.
module chimera_cluster_pwr_seq #(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned RstCycles   = 4,
  parameter int unsigned IsoTimeout  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumClusters-1:0]   pwr_req_i,
  input  logic [NumClusters-1:0]   isolated_i,
  input  logic                     err_clr_i,
  output logic [NumClusters-1:0]   isolate_o,
  output logic [NumClusters-1:0]   clk_en_o,
  output logic [NumClusters-1:0]   cluster_rst_o,
  output logic [NumClusters-1:0]   busy_o,
  output logic [3*NumClusters-1:0] pwr_state_o,
  output logic [NumClusters-1:0]   err_o
);

  localparam int unsigned CntMax = (RstCycles > IsoTimeout) ? RstCycles : IsoTimeout;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);

  typedef enum logic [2:0] {
    StOn       = 3'd0,
    StIso      = 3'd1,
    StRstEnter = 3'd2,
    StOff      = 3'd3,
    StWake     = 3'd4,
    StDeiso    = 3'd5
  } state_e;

  state_e          state_q [NumClusters];
  state_e          state_d [NumClusters];
  logic [CntW-1:0] cnt_q   [NumClusters];
  logic [CntW-1:0] cnt_d   [NumClusters];

  logic [NumClusters-1:0] err_q, err_d, err_set;
  logic [NumClusters-1:0] iso_q, iso_d;
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] crst_q, crst_d;
  logic [NumClusters-1:0] busy_q, busy_d;

  // Output pattern per state: {isolate, clk_en, cluster_rst, busy}.
  function automatic logic [3:0] decode(input state_e s);
    logic [3:0] o;
    case (s)
      StOn:       o = 4'b0100;
      StIso:      o = 4'b1101;
      StRstEnter: o = 4'b1111;
      StOff:      o = 4'b1010;
      StWake:     o = 4'b1111;
      StDeiso:    o = 4'b0101;
      default:    o = 4'b0100;
    endcase
    return o;
  endfunction

  always_comb begin
    err_set = '0;
    for (int c = 0; c < NumClusters; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        StOn: begin
          if (!pwr_req_i[c]) begin
            state_d[c] = StIso;
            cnt_d[c]   = '0;
          end
        end
        StIso: begin
          if (isolated_i[c]) begin
            state_d[c] = StRstEnter;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == IsoLast) begin
            // Ack never arrived: release isolation and flag it.
            state_d[c] = StDeiso;
            cnt_d[c]   = '0;
            err_set[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CntW'(1);
          end
        end
        StRstEnter: begin
          if (cnt_q[c] == RstLast) begin
            state_d[c] = StOff;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CntW'(1);
          end
        end
        StOff: begin
          if (pwr_req_i[c]) begin
            state_d[c] = StWake;
            cnt_d[c]   = '0;
          end
        end
        StWake: begin
          if (cnt_q[c] == RstLast) begin
            state_d[c] = StDeiso;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CntW'(1);
          end
        end
        StDeiso: begin
          if (!isolated_i[c]) begin
            state_d[c] = StOn;
            cnt_d[c]   = '0;
          end
        end
        default: begin
          state_d[c] = StOn;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    err_d = (err_q & ~{NumClusters{err_clr_i}}) | err_set;
  end

  // Outputs are decoded from the next state so they change together with the state register.
  always_comb begin
    iso_d    = '0;
    clk_en_d = '0;
    crst_d   = '0;
    busy_d   = '0;
    for (int c = 0; c < NumClusters; c++) begin
      {iso_d[c], clk_en_d[c], crst_d[c], busy_d[c]} = decode(state_d[c]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumClusters; c++) begin
        state_q[c] <= StOn;
        cnt_q[c]   <= '0;
      end
      err_q    <= '0;
      iso_q    <= '0;
      clk_en_q <= '1;
      crst_q   <= '0;
      busy_q   <= '0;
    end else begin
      for (int c = 0; c < NumClusters; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      err_q    <= err_d;
      iso_q    <= iso_d;
      clk_en_q <= clk_en_d;
      crst_q   <= crst_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    pwr_state_o = '0;
    for (int c = 0; c < NumClusters; c++) begin
      pwr_state_o[3*c +: 3] = state_q[c];
    end
  end

  assign isolate_o     = iso_q;
  assign clk_en_o      = clk_en_q;
  assign cluster_rst_o = crst_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Scoreboard bench for chimera_cluster_pwr_seq: a cycle model pushes expected outputs as stimulus
// is driven; they are popped and compared after the clock edge, plus directed timeline checks.
module tb_chimera_cluster_pwr_seq;

  localparam int unsigned N    = 5;
  localparam int unsigned RstC = 4;
  localparam int unsigned IsoT = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '1;
  logic [N-1:0]   iso_ack = '0;
  logic           clr = 1'b0;
  logic [N-1:0]   isolate, clk_en, crst, busy, err;
  logic [3*N-1:0] pstate;

  always #5 clk = ~clk;

  chimera_cluster_pwr_seq #(
    .NumClusters (N),
    .RstCycles   (RstC),
    .IsoTimeout  (IsoT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pwr_req_i     (req),
    .isolated_i    (iso_ack),
    .err_clr_i     (clr),
    .isolate_o     (isolate),
    .clk_en_o      (clk_en),
    .cluster_rst_o (crst),
    .busy_o        (busy),
    .pwr_state_o   (pstate),
    .err_o         (err)
  );

  typedef struct packed {
    logic [N-1:0]   iso;
    logic [N-1:0]   clk;
    logic [N-1:0]   rst;
    logic [N-1:0]   busy;
    logic [3*N-1:0] st;
    logic [N-1:0]   err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int   m_st  [N];
  int   m_cnt [N];
  logic m_err [N];

  // Isolate-cell emulation: ack rises once isolate_o has been high for ack_dly cycles.
  bit   ack_en  [N];
  int   ack_dly [N];
  int   iso_age [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] out_of(input int s);
    case (s)
      0:       return 4'b0100;
      1:       return 4'b1101;
      2:       return 4'b1111;
      3:       return 4'b1010;
      4:       return 4'b1111;
      5:       return 4'b0101;
      default: return 4'b0100;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      logic [3:0] o;
      logic       set;
      set = 1'b0;
      if (rst) begin
        m_st[c]  = 0;
        m_cnt[c] = 0;
        m_err[c] = 1'b0;
      end else begin
        case (m_st[c])
          0: if (!req[c]) begin m_st[c] = 1; m_cnt[c] = 0; end
          1: begin
            if (iso_ack[c]) begin m_st[c] = 2; m_cnt[c] = 0; end
            else if (m_cnt[c] == IsoT - 1) begin m_st[c] = 5; m_cnt[c] = 0; set = 1'b1; end
            else m_cnt[c]++;
          end
          2: if (m_cnt[c] == RstC - 1) begin m_st[c] = 3; m_cnt[c] = 0; end else m_cnt[c]++;
          3: if (req[c]) begin m_st[c] = 4; m_cnt[c] = 0; end
          4: if (m_cnt[c] == RstC - 1) begin m_st[c] = 5; m_cnt[c] = 0; end else m_cnt[c]++;
          5: if (!iso_ack[c]) begin m_st[c] = 0; m_cnt[c] = 0; end
          default: m_st[c] = 0;
        endcase
        if (clr) m_err[c] = 1'b0;
        if (set) m_err[c] = 1'b1;
      end
      o = out_of(m_st[c]);
      e.iso[c]        = o[3];
      e.clk[c]        = o[2];
      e.rst[c]        = o[1];
      e.busy[c]       = o[0];
      e.st[3*c +: 3]  = 3'(m_st[c]);
      e.err[c]        = m_err[c];
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      iso_ack[c] = ack_en[c] && (iso_age[c] >= ack_dly[c]);
    end
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("isolate", 32'(isolate), 32'(e.iso));
    check("clk_en", 32'(clk_en), 32'(e.clk));
    check("cluster_rst", 32'(crst), 32'(e.rst));
    check("busy", 32'(busy), 32'(e.busy));
    check("pwr_state", 32'(pstate), 32'(e.st));
    check("err", 32'(err), 32'(e.err));
    for (int c = 0; c < N; c++) begin
      iso_age[c] = isolate[c] ? iso_age[c] + 1 : 0;
    end
    clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(pstate), 32'd0);
    check({tag, "_clk_en"}, 32'(clk_en), 32'h1f);
    check({tag, "_isolate"}, 32'(isolate), 32'd0);
    check({tag, "_crst"}, 32'(crst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int rcnt;
    for (int c = 0; c < N; c++) begin
      ack_en[c]  = 1'b1;
      ack_dly[c] = 3;
      iso_age[c] = 0;
    end

    repeat (3) step();
    rst = 1'b0;
    check_reset_vals("reset");

    // Power down cluster 2 only.
    req = 5'b11011;
    step();
    check("pd_iso_t1", 32'(isolate[2]), 32'd1);
    rcnt = 0;
    for (int i = 0; i < 20 && clk_en[2]; i++) begin
      step();
      if (crst[2] && clk_en[2]) rcnt++;
    end
    check("pd_rst_cycles", rcnt, RstC);
    check("pd_clk_off", 32'(clk_en[2]), 32'd0);
    check("pd_state_off", 32'(pstate[8:6]), 32'd3);
    check("pd_others_on", 32'(pstate & ~15'h01c0), 32'd0);

    // Wake cluster 2.
    req = 5'b11111;
    rcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (crst[2] && clk_en[2]) rcnt++;
      if (!crst[2]) break;
    end
    check("wk_rst_cycles", rcnt, RstC);
    check("wk_iso_released", 32'(isolate[2]), 32'd0);
    check("wk_state_deiso", 32'(pstate[8:6]), 32'd5);
    step();
    check("wk_state_on", 32'(pstate[8:6]), 32'd0);
    check("wk_busy", 32'(busy[2]), 32'd0);

    // Isolation timeout on cluster 0.
    ack_en[0] = 1'b0;
    req[0] = 1'b0;
    repeat (17) step();
    check("to_state_deiso", 32'(pstate[2:0]), 32'd5);
    check("to_err", 32'(err[0]), 32'd1);
    step();
    check("to_state_on", 32'(pstate[2:0]), 32'd0);
    step();
    check("to_state_reiso", 32'(pstate[2:0]), 32'd1);
    clr = 1'b1;
    step();
    check("to_err_cleared", 32'(err[0]), 32'd0);
    for (int i = 0; i < 40 && !(m_st[0] == 1 && m_cnt[0] == IsoT - 1); i++) step();
    clr = 1'b1;
    step();
    check("to_set_beats_clr", 32'(err[0]), 32'd1);
    req[0] = 1'b1;
    ack_en[0] = 1'b1;
    repeat (3) step();
    check("to_back_on", 32'(pstate[2:0]), 32'd0);
    clr = 1'b1;
    step();
    check("to_err_clr2", 32'(err[0]), 32'd0);

    // Request toggle during RST_ENTER is ignored until OFF.
    ack_dly[1] = 2;
    req[1] = 1'b0;
    for (int i = 0; i < 20 && pstate[5:3] != 3'd2; i++) step();
    check("mid_rst_enter", 32'(pstate[5:3]), 32'd2);
    req[1] = 1'b1;
    for (int i = 0; i < 10 && pstate[5:3] != 3'd3; i++) step();
    check("mid_off_reached", 32'(pstate[5:3]), 32'd3);
    step();
    check("mid_wake", 32'(pstate[5:3]), 32'd4);
    rst = 1'b1;
    step();
    check_reset_vals("midrst");
    rst = 1'b0;
    step();

    // All clusters down together with staggered acks, then back up.
    for (int c = 0; c < N; c++) ack_dly[c] = c + 1;
    req = '0;
    repeat (30) step();
    check("all_off_state", 32'(pstate), 32'(15'o33333));
    check("all_off_clk", 32'(clk_en), 32'd0);
    req = '1;
    repeat (20) step();
    check("all_on_state", 32'(pstate), 32'd0);
    check("all_on_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
